// File: rtl/inst_fetch_queue_if.sv
// Bus bundle between the instruction fetch queue and its environment:
// the PC generator (pc / pc_enable / flush), the synchronous instruction
// memory (imem_*) and the decode stage (inst_*).
//
// Decode handshake: inst_valid/inst/inst_pc are stable for the whole cycle.
// An entry transfers on a rising CLK edge where inst_valid && inst_ready are
// both high. inst_valid never depends on inst_ready. inst and inst_pc read as
// zero whenever inst_valid is low.
interface inst_fetch_queue_if #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int INST_WIDTH     = 32
);
  logic [INST_MEM_WIDTH-1:0] pc;
  logic                      pc_enable;
  logic                      flush;
  logic                      imem_en;
  logic [INST_MEM_WIDTH-1:0] imem_addr;
  logic [INST_WIDTH-1:0]     imem_rdata;
  logic                      inst_valid;
  logic [INST_WIDTH-1:0]     inst;
  logic [INST_MEM_WIDTH-1:0] inst_pc;
  logic                      inst_ready;

  // Fetch-queue side.
  modport master (
    input  pc, flush, imem_rdata, inst_ready,
    output pc_enable, imem_en, imem_addr, inst_valid, inst, inst_pc
  );

  // Environment side: PC generator, instruction memory and decode.
  modport slave (
    output pc, flush, imem_rdata, inst_ready,
    input  pc_enable, imem_en, imem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: issues one read per cycle to a 1-cycle-latency
// instruction memory while credit allows, buffers {instruction, pc} in a
// DEPTH-entry FIFO and presents the head to decode. flush discards queued
// and in-flight reads.
// Optional macro IFQ_BYPASS_EN: returning data goes straight to decode when
// the FIFO is empty (1-cycle issue-to-valid), and a same-cycle pop counts as
// free space for issue.
module inst_fetch_queue #(
  parameter int INST_MEM_WIDTH = 2,
  parameter int INST_WIDTH     = 32,
  parameter int DEPTH          = 4
) (
  input logic                 CLK,
  input logic                 reset,
  inst_fetch_queue_if.master  bus
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  logic [PW-1:0]             wr_ptr;
  logic [PW-1:0]             rd_ptr;
  logic                      inflight;
  logic [INST_MEM_WIDTH-1:0] inflight_pc;

  logic [INST_WIDTH-1:0]     mem_inst [DEPTH];
  logic [INST_MEM_WIDTH-1:0] mem_pc   [DEPTH];

  logic [PW-1:0]             occupancy;
  logic [PW:0]               used;
  logic                      empty;
  logic                      head_valid;
  logic [INST_WIDTH-1:0]     head_inst;
  logic [INST_MEM_WIDTH-1:0] head_pc;
  logic                      pop;
  logic                      pop_fifo;
  logic                      push;
  logic                      issue;

  assign occupancy = wr_ptr - rd_ptr;
  assign used      = {1'b0, occupancy} + {{PW{1'b0}}, inflight};
  assign empty     = (wr_ptr == rd_ptr);

`ifdef IFQ_BYPASS_EN
  logic bypass;
  assign bypass = empty && inflight && !bus.flush;

  // Head selection with bypass of returning read data, pop/push/issue control.
  always_comb begin
    head_valid = 1'b0;
    head_inst  = '0;
    head_pc    = '0;
    if (!empty && !bus.flush) begin
      head_valid = 1'b1;
      head_inst  = mem_inst[rd_ptr[IW-1:0]];
      head_pc    = mem_pc[rd_ptr[IW-1:0]];
    end else if (bypass) begin
      head_valid = 1'b1;
      head_inst  = bus.imem_rdata;
      head_pc    = inflight_pc;
    end
    pop      = head_valid && bus.inst_ready;
    // A bypassed pop consumes the in-flight read, not a FIFO slot.
    pop_fifo = pop && !empty;
    push     = inflight && !bus.flush && !(bypass && bus.inst_ready);
    issue    = !reset && !bus.flush && ((used - {{PW{1'b0}}, pop}) < DEPTH_W);
  end
`else
  logic full;
  assign full = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);

  // Head from FIFO only, pop/push/issue control; freed space waits a cycle.
  always_comb begin
    head_valid = 1'b0;
    head_inst  = '0;
    head_pc    = '0;
    if (!empty && !bus.flush) begin
      head_valid = 1'b1;
      head_inst  = mem_inst[rd_ptr[IW-1:0]];
      head_pc    = mem_pc[rd_ptr[IW-1:0]];
    end
    pop      = head_valid && bus.inst_ready;
    pop_fifo = pop;
    push     = inflight && !bus.flush;
    issue    = !reset && !bus.flush && !full && (used < DEPTH_W);
  end
`endif

  // Drive the bus; during flush the PC generator loads its redirect target.
  always_comb begin
    bus.imem_en    = issue;
    bus.imem_addr  = bus.pc;
    bus.pc_enable  = !reset && (issue || bus.flush);
    bus.inst_valid = head_valid;
    bus.inst       = head_inst;
    bus.inst_pc    = head_pc;
  end

  // Pointer and in-flight tracking; flush beats push and pop.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else begin
      inflight <= issue;
      if (issue) inflight_pc <= bus.pc;
      if (bus.flush) begin
        rd_ptr <= wr_ptr;
      end else begin
        if (push)     wr_ptr <= wr_ptr + 1'b1;
        if (pop_fifo) rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // FIFO storage; contents are only meaningful between rd_ptr and wr_ptr.
  always_ff @(posedge CLK) begin
    if (push && !reset) begin
      mem_inst[wr_ptr[IW-1:0]] <= bus.imem_rdata;
      mem_pc[wr_ptr[IW-1:0]]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: PC generator and instruction memory models,
// a transaction-level reference (issued PCs in order, with their issue
// cycle) and directed plus random phases. Honours IFQ_BYPASS_EN.
module tb_inst_fetch_queue;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;

  inst_fetch_queue_if #(.INST_MEM_WIDTH(AW), .INST_WIDTH(DW)) bus ();

  inst_fetch_queue #(.INST_MEM_WIDTH(AW), .INST_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  logic [AW-1:0] redirect_pc;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return 32'h1000 + {24'h0, a};
  endfunction

  // PC generator: advance on enable, load redirect target on flush
  always @(posedge CLK or posedge reset) begin
    if (reset) bus.pc <= '0;
    else if (bus.pc_enable) bus.pc <= bus.flush ? redirect_pc : bus.pc + 1'b1;
  end

  // synchronous instruction memory; garbage when not read
  always @(posedge CLK) begin
    bus.imem_rdata <= bus.imem_en ? mem_word(bus.imem_addr) : DW'($urandom());
  end

  // scoreboard
  logic [AW-1:0] exp_q[$];
  int            exp_cyc_q[$];
  int            cyc = 0;
  int            total = 0;
  int            bad = 0;
  int            pops = 0;
  int            obs_issues = 0;
  logic [AW-1:0] first_pop_pc = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: called at a negedge, drives inputs, checks, updates model,
  // returns at the next negedge.
  task automatic step(input logic fl, input logic rdy);
    logic exp_valid, exp_pop, exp_issue;
    int   used;
    bus.flush      = fl;
    bus.inst_ready = rdy;
    #1;
    used      = exp_q.size();
    exp_valid = !fl && (used > 0) && ((cyc - exp_cyc_q[0]) >= LAT);
    exp_pop   = exp_valid && rdy;
    exp_issue = !fl && ((used - ((BYP && exp_pop) ? 1 : 0)) < DEPTH);

    check_eq("inst_valid", bus.inst_valid, exp_valid);
    check_eq("imem_en", bus.imem_en, exp_issue);
    check_eq("pc_enable", bus.pc_enable, exp_issue || fl);
    check_eq("imem_addr", bus.imem_addr, bus.pc);
    if (exp_valid) begin
      check_eq("inst", bus.inst, mem_word(exp_q[0]));
      check_eq("inst_pc", bus.inst_pc, exp_q[0]);
    end else begin
      check_eq("inst_zero", bus.inst, 0);
      check_eq("inst_pc_zero", bus.inst_pc, 0);
    end

    if (bus.imem_en) obs_issues++;
    if (fl) begin
      exp_q.delete();
      exp_cyc_q.delete();
    end else begin
      if (exp_pop) begin
        if (pops == 0) first_pop_pc = exp_q[0];
        pops++;
        void'(exp_q.pop_front());
        void'(exp_cyc_q.pop_front());
      end
      if (exp_issue) begin
        exp_q.push_back(bus.pc);
        exp_cyc_q.push_back(cyc);
      end
    end
    cyc++;
    @(negedge CLK);
  endtask

  // Asynchronous reset in the middle of a cycle; called and returns at a negedge.
  task automatic mid_reset();
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_pc_enable", bus.pc_enable, 0);
    check_eq("rst_imem_en", bus.imem_en, 0);
    check_eq("rst_inst_valid", bus.inst_valid, 0);
    check_eq("rst_inst", bus.inst, 0);
    check_eq("rst_inst_pc", bus.inst_pc, 0);
    @(negedge CLK);
    reset = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush      = 1'b0;
    bus.inst_ready = 1'b0;
    redirect_pc    = '0;

    // reset state
    @(negedge CLK);
    #1;
    check_eq("reset_pc_enable", bus.pc_enable, 0);
    check_eq("reset_imem_en", bus.imem_en, 0);
    check_eq("reset_inst_valid", bus.inst_valid, 0);
    check_eq("reset_inst", bus.inst, 0);
    check_eq("reset_inst_pc", bus.inst_pc, 0);
    @(negedge CLK);
    reset = 1'b0;

    // streaming at full rate; wraps the pointers several times
    pops = 0;
    repeat (20) step(1'b0, 1'b1);
    check_eq("stream_pops", pops, 20 - LAT);
    check_eq("stream_first_pc", first_pop_pc, 0);

    // reset mid-operation with two entries queued
    mid_reset();
    repeat (3) step(1'b0, 1'b0);
    check_eq("pre_reset_valid", bus.inst_valid, 1);
    mid_reset();
    check_eq("post_reset_pc", bus.pc, 0);

    // backpressure: exactly DEPTH issues, pc holds, then drains in order
    obs_issues = 0;
    repeat (8) step(1'b0, 1'b0);
    check_eq("bp_issues", obs_issues, DEPTH);
    check_eq("bp_pc_hold", bus.pc, DEPTH);
    pops = 0;
    repeat (12) step(1'b0, 1'b1);
    check_eq("bp_first_pc", first_pop_pc, 0);

    // flush with three queued plus one in flight
    mid_reset();
    repeat (4) step(1'b0, 1'b0);
    redirect_pc = 8'h40;
    step(1'b1, 1'b0);
    check_eq("flush_pc_loaded", bus.pc, 8'h40);
    pops = 0;
    repeat (6) step(1'b0, 1'b1);
    check_eq("flush_first_pc", first_pop_pc, 8'h40);

    // flush while full with inst_ready high
    repeat (8) step(1'b0, 1'b0);
    pops = 0;
    redirect_pc = 8'h80;
    step(1'b1, 1'b1);
    check_eq("flush_full_pops", pops, 0);
    bus.flush = 1'b0;
    #1;
    check_eq("flush_full_next_valid", bus.inst_valid, 0);
    repeat (6) step(1'b0, 1'b1);

    // random traffic
    repeat (400) begin
      logic fl, rdy;
      fl  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      if (fl) redirect_pc = AW'($urandom());
      step(fl, rdy);
      if ($urandom_range(0, 99) == 0) mid_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
